// File: rtl/gnr_attractor_ctrl.sv
// Floyd tortoise/hare attractor finder driving a two-copy boolean gene-regulatory network array.
// Build option: define GNR_CYCLE_COUNT_EN to add the run_cycles output.
`timescale 1ns/1ps
module gnr_attractor_ctrl #(
   parameter int N_NODES   = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STEPS = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_NODES-1:0] init_in,
   input  logic [N_NODES-1:0] state_s0,
   input  logic [N_NODES-1:0] state_s1,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [CNT_W-1:0]   mu_len,
   output logic [CNT_W-1:0]   lambda_len,
`ifdef GNR_CYCLE_COUNT_EN
   output logic [31:0]        run_cycles,
`endif
   output logic [N_NODES-1:0] attractor_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FIND, S_PER, S_RELOAD, S_ADV, S_MU, S_DONE
   } state_e;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_e               state_q;
   logic [CNT_W-1:0]     step_q;     // k in FIND, l in PER, a in ADV, m in MU
   logic                 phase_b_q;
   logic [CNT_W-1:0]     mu_q, lambda_q;
   logic [N_NODES-1:0]   init_q, att_q;
   logic                 busy_q, done_q, timeout_q;
   logic                 eq, hit;
   logic                 adv_s0, adv_s1;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      eq     = (state_s0 == state_s1);
      // s0 only equals f^(k/2) at even k; k=0 is the trivial start match
      hit    = eq && !step_q[0] && (step_q >= CNT_W'(2));
      adv_s0 = 1'b0;
      adv_s1 = 1'b0;
      case (state_q)
         S_FIND: begin
            adv_s0 = !hit;
            adv_s1 = !hit;
         end
         S_PER:  adv_s1 = !((step_q != '0) && eq);
         S_ADV:  adv_s1 = 1'b1;
         S_MU: begin
            if (phase_b_q) begin
               adv_s0 = 1'b1;
            end else begin
               adv_s0 = !eq;
               adv_s1 = !eq;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         step_q    <= '0;
         phase_b_q <= 1'b0;
         mu_q      <= '0;
         lambda_q  <= '0;
         init_q    <= '0;
         att_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  init_q    <= init_in;
                  mu_q      <= '0;
                  lambda_q  <= '0;
                  att_q     <= '0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               step_q  <= '0;
               state_q <= S_FIND;
            end
            S_FIND: begin
               if (hit) begin
                  att_q   <= state_s0;
                  step_q  <= '0;
                  state_q <= S_PER;
               end else if (step_q == MAX_CNT) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  step_q <= step_q + ONE;
               end
            end
            S_PER: begin
               if ((step_q != '0) && eq) begin
                  lambda_q <= step_q;
                  state_q  <= S_RELOAD;
               end else begin
                  step_q <= step_q + ONE;
               end
            end
            S_RELOAD: begin
               step_q  <= '0;
               state_q <= S_ADV;
            end
            S_ADV: begin
               // lambda_len >= 1 here, so ADV lasts exactly lambda_len cycles
               if (step_q == lambda_q - ONE) begin
                  step_q    <= '0;
                  phase_b_q <= 1'b0;
                  state_q   <= S_MU;
               end else begin
                  step_q <= step_q + ONE;
               end
            end
            S_MU: begin
               if (!phase_b_q) begin
                  if (eq) begin
                     mu_q    <= step_q;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     phase_b_q <= 1'b1;
                  end
               end else begin
                  phase_b_q <= 1'b0;
                  step_q    <= step_q + ONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef GNR_CYCLE_COUNT_EN
   logic [31:0] cyc_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (start) cyc_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
      end
   end
   assign run_cycles = cyc_q;
`endif

   assign reset_nos       = (state_q == S_LOAD) || (state_q == S_RELOAD);
   assign start_s0        = adv_s0;
   assign start_s1        = adv_s1;
   assign init_state      = init_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign timeout         = timeout_q;
   assign mu_len          = mu_q;
   assign lambda_len      = lambda_q;
   assign attractor_state = att_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: behavioural two-copy networks around two controllers, scoreboard of expected results.
`timescale 1ns/1ps
module tb_gnr_attractor_ctrl;

   typedef struct {
      int          inst;
      logic [3:0]  init;
      logic [15:0] mu;
      logic [15:0] lam;
      logic        to;
      logic [15:0] att_set;  // bit v set => attractor value v is acceptable; all ones = not checked
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        start_a, start_b;
   logic [3:0]  init_a, init_b;
   logic [3:0]  s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;
   logic        par_a = 1'b0, par_b = 1'b0;
   logic [3:0]  is_a, is_b, att_a, att_b;
   logic        rn_a, rn_b, ss0_a, ss0_b, ss1_a, ss1_b;
   logic        busy_a, busy_b, done_a, done_b, to_a, to_b;
   logic [15:0] mu_a, mu_b, lam_a, lam_b;
`ifdef GNR_CYCLE_COUNT_EN
   logic [31:0] cyc_a, cyc_b;
`endif

   int   mode_a;
   int   total = 0;
   int   bad = 0;
   int   rn_cnt_a = 0;
   int   done_cnt_a = 0;
   int   viol = 0;
   exp_t sb[$];

   gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(4096)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .init_in(init_a),
      .state_s0(s0_a), .state_s1(s1_a), .reset_nos(rn_a), .init_state(is_a),
      .start_s0(ss0_a), .start_s1(ss1_a), .busy(busy_a), .done(done_a),
      .timeout(to_a), .mu_len(mu_a), .lambda_len(lam_a),
`ifdef GNR_CYCLE_COUNT_EN
      .run_cycles(cyc_a),
`endif
      .attractor_state(att_a));

   gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .init_in(init_b),
      .state_s0(s0_b), .state_s1(s1_b), .reset_nos(rn_b), .init_state(is_b),
      .start_s0(ss0_b), .start_s1(ss1_b), .busy(busy_b), .done(done_b),
      .timeout(to_b), .mu_len(mu_b), .lambda_len(lam_b),
`ifdef GNR_CYCLE_COUNT_EN
      .run_cycles(cyc_b),
`endif
      .attractor_state(att_b));

   // 0 identity, 1 shift right, 2 3-bit rotate left, 3 3-bit increment
   function automatic logic [3:0] f_net(int mode, logic [3:0] x);
      logic [2:0] lo;
      lo = x[2:0] + 3'd1;
      case (mode)
         1:       return x >> 1;
         2:       return {1'b0, x[1:0], x[2]};
         3:       return {1'b0, lo};
         default: return x;
      endcase
   endfunction

   // Node array: s1 steps per start_s1, s0 steps on the odd-numbered start_s0 pulses after a load
   always @(posedge clk) begin
      if (rn_a === 1'b1) begin
         s0_a <= is_a; s1_a <= is_a; par_a <= 1'b0;
      end else begin
         if (ss1_a === 1'b1) s1_a <= f_net(mode_a, s1_a);
         if (ss0_a === 1'b1) begin
            if (!par_a) s0_a <= f_net(mode_a, s0_a);
            par_a <= ~par_a;
         end
      end
      if (rn_b === 1'b1) begin
         s0_b <= is_b; s1_b <= is_b; par_b <= 1'b0;
      end else begin
         if (ss1_b === 1'b1) s1_b <= f_net(3, s1_b);
         if (ss0_b === 1'b1) begin
            if (!par_b) s0_b <= f_net(3, s0_b);
            par_b <= ~par_b;
         end
      end
   end

   always @(negedge clk) begin
      if (rn_a === 1'b1) rn_cnt_a <= rn_cnt_a + 1;
      if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
      if ((rn_a === 1'b1 && (ss0_a !== 1'b0 || ss1_a !== 1'b0)) ||
          (rn_b === 1'b1 && (ss0_b !== 1'b0 || ss1_b !== 1'b0)))
         viol <= viol + 1;
   end

   task automatic drive_start(int inst, logic [3:0] init);
      @(negedge clk);
      if (inst == 0) begin start_a = 1'b1; init_a = init; end
      else begin start_b = 1'b1; init_b = init; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic launch(exp_t e);
      sb.push_back(e);
      drive_start(e.inst, e.init);
   endtask

   // Pops the oldest expectation and compares it against the next done pulse
   task automatic wait_done(string name, bit poke);
      exp_t        e;
      bit          seen;
      logic        bz, to;
      logic [15:0] mu, lam;
      logic [3:0]  att;
      e = sb.pop_front();
      seen = 1'b0;
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(negedge clk);
         if ((e.inst == 0 ? done_a : done_b) === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s done: no done pulse within 20000 cycles", name);
         return;
      end
      if (poke && e.inst == 0) begin start_a = 1'b1; init_a = ~e.init; end
      bz  = (e.inst == 0) ? busy_a : busy_b;
      to  = (e.inst == 0) ? to_a   : to_b;
      mu  = (e.inst == 0) ? mu_a   : mu_b;
      lam = (e.inst == 0) ? lam_a  : lam_b;
      att = (e.inst == 0) ? att_a  : att_b;
      total++;
      if (mu !== e.mu) begin bad++; $display("FAIL %s mu_len: got %0d want %0d", name, mu, e.mu); end
      total++;
      if (lam !== e.lam) begin bad++; $display("FAIL %s lambda_len: got %0d want %0d", name, lam, e.lam); end
      total++;
      if (to !== e.to) begin bad++; $display("FAIL %s timeout: got %b want %b", name, to, e.to); end
      total++;
      if (bz !== 1'b0) begin bad++; $display("FAIL %s busy at done: got %b want 0", name, bz); end
      if (e.att_set != 16'hFFFF) begin
         total++;
         if (e.att_set[att] !== 1'b1) begin
            bad++; $display("FAIL %s attractor_state: got %b allowed set %h", name, att, e.att_set);
         end
      end
      if (poke) begin
         @(negedge clk);
         start_a = 1'b0;
         total++;
         if (busy_a !== 1'b0) begin bad++; $display("FAIL %s start in DONE: busy got %b want 0", name, busy_a); end
         total++;
         if (is_a !== e.init) begin bad++; $display("FAIL %s init_state held: got %b want %b", name, is_a, e.init); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy_a, done_a, rn_a, ss0_a, ss1_a, to_a} !== 6'b0) begin
         bad++; $display("FAIL reset controls: got %b want 000000", {busy_a, done_a, rn_a, ss0_a, ss1_a, to_a});
      end
      total++;
      if ({mu_a, lam_a, att_a, is_a} !== 40'b0) begin
         bad++; $display("FAIL reset results: got %h want 0", {mu_a, lam_a, att_a, is_a});
      end
      total++;
      if ({busy_b, done_b, rn_b, ss0_b, ss1_b, to_b} !== 6'b0) begin
         bad++; $display("FAIL reset controls b: got %b want 000000", {busy_b, done_b, rn_b, ss0_b, ss1_b, to_b});
      end
      rst = 1'b0;
   endtask

   task automatic test_identity();
      mode_a = 0;
      launch('{0, 4'b1010, 16'd0, 16'd1, 1'b0, 16'h0400});
      wait_done("identity", 1'b0);
   endtask

   task automatic test_shift();
      mode_a = 1;
      launch('{0, 4'b1000, 16'd4, 16'd1, 1'b0, 16'h0001});
      wait_done("shift", 1'b0);
   endtask

   task automatic test_rotate();
      int rn0;
      mode_a = 2;
      rn0 = rn_cnt_a;
      launch('{0, 4'b0001, 16'd0, 16'd3, 1'b0, 16'h0016});
      wait_done("rotate", 1'b0);
      @(negedge clk);
      total++;
      if (rn_cnt_a - rn0 !== 2) begin
         bad++; $display("FAIL rotate reset_nos pulses: got %0d want 2", rn_cnt_a - rn0);
      end
   endtask

   task automatic test_timeout();
      launch('{1, 4'd5, 16'd0, 16'd0, 1'b1, 16'hFFFF});
      wait_done("timeout", 1'b0);
   endtask

   task automatic test_abort();
      int d0;
      mode_a = 2;
      d0 = done_cnt_a;
      drive_start(0, 4'b0001);
      repeat (9) @(negedge clk);
      total++;
      if ({busy_a, ss0_a, ss1_a} !== 3'b101) begin
         bad++; $display("FAIL abort PER strobes: got %b want 101", {busy_a, ss0_a, ss1_a});
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy_a, done_a, ss0_a, ss1_a, rn_a, lam_a} !== 21'b0) begin
         bad++; $display("FAIL abort reset outputs: got %h want 0", {busy_a, done_a, ss0_a, ss1_a, rn_a, lam_a});
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (done_cnt_a !== d0) begin
         bad++; $display("FAIL abort done pulses: got %0d want 0", done_cnt_a - d0);
      end
      launch('{0, 4'b0010, 16'd0, 16'd3, 1'b0, 16'h0016});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start_a = 1'b1;
         init_a = 4'b0111;
         @(negedge clk);
         start_a = 1'b0;
         total++;
         if (is_a !== 4'b0010) begin
            bad++; $display("FAIL busy start ignored: init_state got %b want 0010", is_a);
         end
      end
      wait_done("abort rerun", 1'b0);
      @(negedge clk);
      total++;
      if (done_cnt_a - d0 !== 1) begin
         bad++; $display("FAIL rerun done pulses: got %0d want 1", done_cnt_a - d0);
      end
   endtask

   task automatic test_start_in_done();
      mode_a = 0;
      launch('{0, 4'b0101, 16'd0, 16'd1, 1'b0, 16'h0020});
      wait_done("start in done", 1'b1);
   endtask

`ifdef GNR_CYCLE_COUNT_EN
   function automatic logic [3:0] iter(int mode, logic [3:0] x, int n);
      logic [3:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = f_net(mode, y);
      return y;
   endfunction

   // Cycles LOAD..DONE: LOAD, FIND k+1, PER lambda+1, RELOAD, ADV lambda, MU 2*mu+1, DONE
   function automatic int model_cycles(int mode, logic [3:0] x);
      int k, lam, mu;
      logic [3:0] att, y;
      k = 2;
      while (iter(mode, x, k / 2) != iter(mode, x, k)) k += 2;
      att = iter(mode, x, k / 2);
      y = f_net(mode, att);
      lam = 1;
      while (y != att) begin y = f_net(mode, y); lam++; end
      mu = 0;
      while (iter(mode, x, mu) != iter(mode, x, mu + lam)) mu++;
      return 1 + (k + 1) + (lam + 1) + 1 + lam + (2 * mu + 1) + 1;
   endfunction

   task automatic test_cycle_count();
      int want;
      mode_a = 0;
      want = model_cycles(0, 4'b0011);
      launch('{0, 4'b0011, 16'd0, 16'd1, 1'b0, 16'h0008});
      wait_done("cycle count run", 1'b0);
      @(negedge clk);
      total++;
      if (cyc_a !== 32'(want)) begin
         bad++; $display("FAIL run_cycles: got %0d want %0d", cyc_a, want);
      end
   endtask
`endif

   task automatic test_exclusive();
      total++;
      if (viol !== 0) begin
         bad++; $display("FAIL reset_nos overlap: got %0d overlapping cycles want 0", viol);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      init_a = '0;
      init_b = '0;
      mode_a = 0;
      test_reset();
      test_identity();
      test_shift();
      test_rotate();
      test_timeout();
      test_abort();
      test_start_in_done();
`ifdef GNR_CYCLE_COUNT_EN
      test_cycle_count();
`endif
      test_exclusive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
